pulse_meas_sched: RTL
=====================

# pulse_meas_sched

Time-multiplexes one `pulse_measure` period/width unit across `NUM_CH` pulse inputs. The block selects one channel at a time and waits a fixed number of 1 s gate ticks so the unit settles on the new signal. It then captures the unit's period/width results into a per-channel result file, advances round-robin, and flags each completed scan. It sits between the external pulse pins and the measurement unit; host logic reads results through a registered read port.

## Interface
- `NUM_CH`, 4: number of pulse channels (2..16).
- `CH_W`, 2: channel index width, equal to clog2(`NUM_CH`).
- `SETTLE_GATES`, 2: `pulse_1s` ticks counted after a channel switch before capture (1..15).
- `CAP_DLY`, 4: clock cycles from the last counted tick to the capture, covering the unit's timeout/output pipeline (1..15).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  scan enable.
- `pulse_1s`  in  1  one-cycle 1 s gate tick (shared with the measurement unit).
- `pulse_in`  in  `NUM_CH`  raw pulse inputs.
- `pulse_sel`  out  1  selected pulse, driven to the unit's `pulse` input.
- `meas_period`  in  32  period result from the unit.
- `meas_width`  in  32  width result from the unit.
- `cur_ch`  out  `CH_W`  channel currently routed.
- `rd_ch`  in  `CH_W`  read address.
- `rd_period`  out  32  stored period of `rd_ch`.
- `rd_width`  out  32  stored width of `rd_ch`.
- `rd_valid`  out  1  stored period of `rd_ch` is nonzero.
- `scan_done`  out  1  one-cycle pulse when the last channel of a scan is captured.

## Operation
- **FSM states:** IDLE, SWITCH, SETTLE, WAIT_DLY, CAPTURE.
- **IDLE:**
  - `pulse_sel`=0.
  - `ena`=1 → SWITCH, with `cur_ch` = first enabled channel from 0.
- **SWITCH** (1 cycle): clear the gate counter, then go to SETTLE.
- **SETTLE:**
  - Each `pulse_1s` increments the gate counter.
  - When the counter reaches `SETTLE_GATES`, go to WAIT_DLY with the delay counter = 0.
  - A `pulse_1s` arriving in the SWITCH cycle is not counted.
- **WAIT_DLY:** count `CAP_DLY` cycles, then go to CAPTURE.
- **CAPTURE** (1 cycle):
  - Write `meas_period`/`meas_width` into entry `cur_ch`; the valid bit is set to (`meas_period`≠0).
  - Advance `cur_ch` to the next enabled channel, wrapping `NUM_CH`-1 → 0, then go to SWITCH.
  - `scan_done`=1 in the CAPTURE cycle of the highest-index enabled channel.
- **`pulse_sel` routing:** `pulse_sel` <= `pulse_in[cur_ch]`, registered, in every state except IDLE.
- **Stale results:** with `SETTLE_GATES`≥2, the unit's own timeout zeroes results for a dead channel, so a silent input stores 0 / invalid.
- **`ena` deasserted in any state:** go to IDLE on the next cycle. No capture is performed for the aborted channel, and stored results are retained. Re-enabling restarts at the first enabled channel.
- **Reset mid-scan:** all state is cleared immediately (asynchronous).
- **Read port:** `rd_period`/`rd_width`/`rd_valid` are registered, with 1-cycle latency from `rd_ch`. If a read and a capture hit the same entry in the same cycle, the read returns the old value.

## Timing
- **Reset values:**
  - FSM = IDLE; `cur_ch`=0; `pulse_sel`=0; `scan_done`=0.
  - `rd_period`/`rd_width`=0; `rd_valid`=0.
  - All result entries = 0 and invalid.
- **Per-channel dwell:** 1 (SWITCH) + time to `SETTLE_GATES` ticks + `CAP_DLY` + 1 (CAPTURE) cycles.
- **Switch latency:** `pulse_sel` reflects the new channel 1 cycle after `cur_ch` changes.
- **Counters:** gate and delay counters are 4-bit, saturating compares with `==`, with no wrap.

## Configuration
- **`PULSE_SCHED_MASK_EN` defined:**
  - Adds input `ch_mask` [`NUM_CH`-1:0]; only channels with a 1 are scanned.
  - The mask is sampled at IDLE exit and at every CAPTURE when choosing the next channel.
  - Skipped channels keep their previous results.
  - An all-zero mask holds the FSM in IDLE, with `scan_done` never asserted.
- **Undefined:** all channels are scanned and `scan_done` follows channel `NUM_CH`-1.

## Structure
- **Package `pulse_meas_pkg`:**
  - FSM state enum.
  - `PM_DATA_W`=32.
  - Counter width constant `PM_CNT_W`=4.
- **One sub-module `pulse_result_regs`:** `NUM_CH`×(32+32+1) entries with a write port (CAPTURE) and a registered read port. The FSM, mux and next-channel logic stay in the top.

## Test plan
- **Basic scan:** reset, `ena`=1, `pulse_in`[0] period 100/width 30 cycles, others idle, `SETTLE_GATES`=2 → entry 0 = 100/30 valid; entries 1..3 = 0 invalid; `scan_done` once per scan after channel 3.
- **Dwell timing:** `pulse_1s` every 1000 cycles → `cur_ch` sequence 0,1,2,3,0. Each CAPTURE occurs exactly `CAP_DLY`+1 cycles after the 2nd tick following SWITCH.
- **Abort and restart:** drop `ena` in WAIT_DLY of channel 2 → IDLE next cycle, entry 2 unchanged, `pulse_sel`=0. Re-raise `ena` → restarts at channel 0.
- **Read/write collision:** `rd_ch`=1 in the channel 1 CAPTURE cycle → old value returned; new value returned the following cycle.
- **Reset mid-scan:** assert `rst` during SETTLE → all outputs 0 asynchronously and all entries invalid.
- **Mask (`PULSE_SCHED_MASK_EN`):** `ch_mask`=4'b1010 → only channels 1 and 3 are visited and `scan_done` follows channel 3. `ch_mask`=0 → FSM stays in IDLE.

Source files
------------

// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse measurement scheduler.
package pulse_meas_pkg;

    localparam int PM_DATA_W = 32;
    localparam int PM_CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWITCH,
        S_SETTLE,
        S_WAIT_DLY,
        S_CAPTURE
    } pm_state_e;

endpackage

// File: rtl/pulse_result_regs.sv
// Per-channel result file: one capture write port, one registered read port.
// A read and a write to the same entry in one cycle returns the old value.
module pulse_result_regs
    import pulse_meas_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [PM_DATA_W-1:0] wr_period,
    input  logic [PM_DATA_W-1:0] wr_width,
    input  logic [CH_W-1:0]      rd_ch,
    output logic [PM_DATA_W-1:0] rd_period,
    output logic [PM_DATA_W-1:0] rd_width,
    output logic                 rd_valid
);

    logic [NUM_CH-1:0][PM_DATA_W-1:0] period_q, width_q;
    logic [NUM_CH-1:0]                valid_q;
    logic [PM_DATA_W-1:0]             rd_period_q, rd_width_q;
    logic                             rd_valid_q;

    // Storage array; a zero period marks the entry invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            width_q  <= '0;
            valid_q  <= '0;
        end else if (wr_en) begin
            period_q[wr_ch] <= wr_period;
            width_q[wr_ch]  <= wr_width;
            valid_q[wr_ch]  <= |wr_period;
        end
    end

    // Registered read samples the pre-write contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_period_q <= '0;
            rd_width_q  <= '0;
            rd_valid_q  <= 1'b0;
        end else if (int'(rd_ch) < NUM_CH) begin
            rd_period_q <= period_q[rd_ch];
            rd_width_q  <= width_q[rd_ch];
            rd_valid_q  <= valid_q[rd_ch];
        end else begin
            rd_period_q <= '0;
            rd_width_q  <= '0;
            rd_valid_q  <= 1'b0;
        end
    end

    assign rd_period = rd_period_q;
    assign rd_width  = rd_width_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: rtl/pulse_meas_sched.sv
// Round-robin scheduler sharing one period/width measurement unit across
// NUM_CH pulse inputs. Optional channel mask: define PULSE_SCHED_MASK_EN.
module pulse_meas_sched
    import pulse_meas_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int SETTLE_GATES = 2,
    parameter int CAP_DLY      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 pulse_1s,
    input  logic [NUM_CH-1:0]    pulse_in,
`ifdef PULSE_SCHED_MASK_EN
    input  logic [NUM_CH-1:0]    ch_mask,
`endif
    output logic                 pulse_sel,
    input  logic [PM_DATA_W-1:0] meas_period,
    input  logic [PM_DATA_W-1:0] meas_width,
    output logic [CH_W-1:0]      cur_ch,
    input  logic [CH_W-1:0]      rd_ch,
    output logic [PM_DATA_W-1:0] rd_period,
    output logic [PM_DATA_W-1:0] rd_width,
    output logic                 rd_valid,
    output logic                 scan_done
);

    localparam logic [PM_CNT_W-1:0] SETTLE_N = PM_CNT_W'(SETTLE_GATES);
    localparam logic [PM_CNT_W-1:0] CAP_N    = PM_CNT_W'(CAP_DLY);

    pm_state_e             state_q, state_d;
    logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
    logic [PM_CNT_W-1:0]   gate_q, gate_d;
    logic [PM_CNT_W-1:0]   dly_q, dly_d;
    logic                  pulse_sel_q;
    logic                  cap_we;
    logic [NUM_CH-1:0]     mask;

`ifdef PULSE_SCHED_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    // Lowest enabled channel
    function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) r = CH_W'(i);
        return r;
    endfunction

    // Next enabled channel after c, wrapping; c itself if it is the only one
    function automatic logic [CH_W-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                                input logic [CH_W-1:0]   c);
        logic [CH_W-1:0] r;
        int              idx;
        r = c;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(c) + k) % NUM_CH;
            if (m[idx]) r = CH_W'(idx);
        end
        return r;
    endfunction

    // Highest enabled channel closes a scan
    function automatic logic [CH_W-1:0] last_ch(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (m[i]) r = CH_W'(i);
        return r;
    endfunction

    // State, channel and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cur_ch_q <= '0;
            gate_q   <= '0;
            dly_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            gate_q   <= gate_d;
            dly_q    <= dly_d;
        end
    end

    // Next-state logic; dropping ena aborts from any state without capture
    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        gate_d   = gate_q;
        dly_d    = dly_q;
        cap_we   = 1'b0;
        if (!ena) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|mask) begin
                        state_d  = S_SWITCH;
                        cur_ch_d = first_ch(mask);
                    end
                end
                S_SWITCH: begin
                    // a gate tick landing here is deliberately dropped
                    gate_d  = '0;
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (pulse_1s && gate_q != '1) gate_d = gate_q + 1'b1;
                    if (gate_d == SETTLE_N) begin
                        state_d = S_WAIT_DLY;
                        dly_d   = '0;
                    end
                end
                S_WAIT_DLY: begin
                    if (dly_q != '1) dly_d = dly_q + 1'b1;
                    if (dly_d == CAP_N) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    cap_we = 1'b1;
                    if (|mask) begin
                        cur_ch_d = next_ch(mask, cur_ch_q);
                        state_d  = S_SWITCH;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered pulse mux, forced low while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse_sel_q <= 1'b0;
        else     pulse_sel_q <= (state_d != S_IDLE) ? pulse_in[cur_ch_q] : 1'b0;
    end

    assign pulse_sel = pulse_sel_q;
    assign cur_ch    = cur_ch_q;
    assign scan_done = cap_we && (cur_ch_q == last_ch(mask));

    pulse_result_regs #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (cap_we),
        .wr_ch     (cur_ch_q),
        .wr_period (meas_period),
        .wr_width  (meas_width),
        .rd_ch     (rd_ch),
        .rd_period (rd_period),
        .rd_width  (rd_width),
        .rd_valid  (rd_valid)
    );

endmodule
